// File: rtl/dpram_burst_reader_pkg.sv
// dpram_rd_pkg: shared state encoding and FIFO depth for the burst reader
package dpram_rd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int FIFO_DEPTH = 3;
endpackage

// File: rtl/dpram_burst_reader_if.sv
// dpram_burst_reader_if: valid/ready word stream with end-of-burst marker
interface dpram_burst_reader_if #(parameter int DW = 8);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  modport master(output out_valid, out_data, out_last, input out_ready);
  modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/dpram_burst_reader_fifo.sv
// small_sync_fifo: 3-entry shift FIFO whose head is always entry 0, so the output is straight from a register
module small_sync_fifo
  import dpram_rd_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [W-1:0] nxt [FIFO_DEPTH];
  logic [1:0]   wr_idx;
  assign wr_idx = count - 2'(pop);
  assign head   = mem[0];
  always_comb begin
    nxt = mem;
    for (int i = 0; i < FIFO_DEPTH - 1; i++) if (pop) nxt[i] = mem[i+1];
    if (push) nxt[wr_idx] = din;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      mem   <= nxt;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/dpram_burst_reader.sv
// dpram_burst_reader: sweeps a wrapping RAM address range and streams the words out with backpressure
module dpram_burst_reader
  import dpram_rd_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] length,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_q,
  dpram_burst_reader_if.master stream
);
  state_t        state, state_nxt;
  logic [LW-1:0] iss_rem, beat_rem;
  logic          inflight, inflight_last;
  logic [1:0]    fifo_count;
  logic          accept, flush, issue, hs, finish;
  assign busy             = state != IDLE;
  assign stream.out_valid = fifo_count != '0;
  assign hs               = stream.out_valid & stream.out_ready;
  always_comb begin
    accept    = state == IDLE && start && !abort;
    flush     = busy && abort;
    issue     = state == RUN && !abort && (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    finish    = state == DRAIN && !abort && hs && beat_rem == LW'(1);
    state_nxt = flush ? IDLE :
                (accept && length != '0) ? RUN :
                (issue && iss_rem == LW'(1)) ? DRAIN :
                finish ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end
  // ram_addr always holds the next address to read; it only advances when a read is credited
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr      <= '0;
      iss_rem       <= '0;
      beat_rem      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= finish || (accept && length == '0);
      inflight      <= issue;
      inflight_last <= issue && iss_rem == LW'(1);
      if (accept) begin
        ram_addr <= start_addr;
        iss_rem  <= length;
        beat_rem <= length;
      end else begin
        if (issue) begin
          ram_addr <= ram_addr + 1'b1;
          iss_rem  <= iss_rem - 1'b1;
        end
        if (hs) beat_rem <= beat_rem - 1'b1;
      end
    end
  end
  small_sync_fifo #(.W(DW + 1)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .pop     (hs),
    .flush   (flush),
    .din     ({inflight_last, ram_q}),
    .count   (fifo_count),
    .head    ({stream.out_last, stream.out_data})
  );
endmodule

// File: tb/tb_dpram_burst_reader.sv
// tb_dpram_burst_reader: directed checks of latency, wrap, backpressure, zero length, abort, ignored start and async reset
module tb_dpram_burst_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] length = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_q = '0;
  logic [7:0]  mem [1024];
  int          passed = 0;
  int          total = 0;
  dpram_burst_reader_if #(.DW(8)) s ();
  dpram_burst_reader #(.DW(8), .AW(10), .LW(11)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_q      (ram_q),
    .stream     (s)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[ram_addr];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  always @(negedge clk) if (reset_n && busy) check("credit", 32'(int'(dut.fifo_count) + int'(dut.inflight) <= 3), 32'd1);
  task automatic kick(input logic [9:0] a, input logic [10:0] n);
    @(negedge clk);
    start = 1'b1; start_addr = a; length = n;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic stream_chk(input logic [9:0] a, input int n, input int len, input logic [15:0] pat, input string tag);
    int k = 0;
    int cyc = 0;
    logic held_v = 1'b0;
    logic [8:0] held = '0;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      s.out_ready = pat[cyc % 16];
      if (held_v) check({tag, "_hold"}, {s.out_valid, s.out_last, s.out_data}, {1'b1, held});
      held_v = s.out_valid && !s.out_ready;
      held   = {s.out_last, s.out_data};
      if (s.out_valid && s.out_ready) begin
        check({tag, "_beat"}, {s.out_last, s.out_data}, {k == len - 1, mem[10'(int'(a) + k)]});
        k++;
      end
    end
    check({tag, "_count"}, k, n);
  endtask
  task automatic done_chk(input string tag);
    @(negedge clk);
    check({tag, "_done"}, {done, busy, s.out_valid}, 3'b100);
    @(negedge clk);
    check({tag, "_done_off"}, done, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[10'h010] = 8'hA0; mem[10'h011] = 8'hA1; mem[10'h012] = 8'hA2; mem[10'h013] = 8'hA3;
    s.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", {busy, done, ram_addr, s.out_valid, s.out_data, s.out_last}, '0);
    reset_n = 1'b1;
    // basic burst: exact cycle latency
    kick(10'h010, 11'd4);
    check("t1_addr", {busy, ram_addr}, {1'b1, 10'h010});
    @(negedge clk);
    check("t1_c2", s.out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_beat", {s.out_valid, s.out_last, s.out_data, done}, {1'b1, k == 3, 8'hA0 + 8'(k), 1'b0});
    end
    done_chk("t1");
    // address wrap, ram_addr observed under backpressure
    s.out_ready = 1'b0;
    kick(10'h3FE, 11'd4);
    check("t2_a0", ram_addr, 10'h3FE);
    @(negedge clk); check("t2_a1", ram_addr, 10'h3FF);
    @(negedge clk); check("t2_a2", ram_addr, 10'h000);
    @(negedge clk); check("t2_a3", ram_addr, 10'h001);
    stream_chk(10'h3FE, 4, 4, 16'hFFFF, "t2");
    done_chk("t2");
    // toggling backpressure
    kick(10'h080, 11'd8);
    stream_chk(10'h080, 8, 8, 16'b0110_1001_0101_1001, "t3");
    done_chk("t3");
    s.out_ready = 1'b1;
    // zero length
    kick(10'h040, 11'd0);
    check("t4_done", {done, busy, s.out_valid}, 3'b100);
    @(negedge clk);
    check("t4_after", {done, busy, s.out_valid}, 3'b000);
    // abort after five handshakes
    kick(10'h100, 11'd16);
    stream_chk(10'h100, 5, 16, 16'hFFFF, "t5");
    @(negedge clk);
    s.out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort", {s.out_valid, busy, done}, 3'b000);
    @(negedge clk);
    check("t5_nodone", {s.out_valid, busy, done}, 3'b000);
    s.out_ready = 1'b1;
    kick(10'h020, 11'd2);
    stream_chk(10'h020, 2, 2, 16'hFFFF, "t5b");
    done_chk("t5b");
    // start while busy is ignored
    s.out_ready = 1'b0;
    kick(10'h200, 11'd6);
    start = 1'b1; start_addr = 10'h300; length = 11'd3;
    @(negedge clk);
    start = 1'b0;
    stream_chk(10'h200, 6, 6, 16'hFFFF, "t6");
    done_chk("t6");
    // asynchronous reset mid-burst
    kick(10'h050, 11'd8);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t7_reset", {busy, done, ram_addr, s.out_valid, s.out_data, s.out_last}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    kick(10'h3FF, 11'd1);
    stream_chk(10'h3FF, 1, 1, 16'hFFFF, "t7b");
    done_chk("t7b");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
